// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory request path.
//  - MODE_* : request mode encoding, also used by the front-panel I/O controller
//  - bridge_state_t : one-hot state encoding of mem_request_bridge
//  - mode_is_valid() : true for the two modes that start an Avalon transaction
package mem_ctrl_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_RD_CMD  = 6'b000010,
    ST_RD_WAIT = 6'b000100,
    ST_WR_CMD  = 6'b001000,
    ST_DONE    = 6'b010000,
    ST_REARM   = 6'b100000
  } bridge_state_t;

  function automatic logic mode_is_valid(input logic [1:0] m);
    return (m == MODE_READ) || (m == MODE_WRITE);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Transaction watchdog counter.
//  clk      in  system clock
//  reset_n  in  asynchronous active-low reset
//  clear    in  synchronous clear (request accepted)
//  enable   in  count this cycle (transaction in flight)
//  expired  out count has reached TIMEOUT_CYCLES-1
// The count saturates at its terminal value so expired stays asserted
// until the next clear.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_request_bridge.sv
// Converts the I/O controller's level-held request into one single-word
// Avalon-MM master transaction and returns a one-cycle completion pulse.
//  clk, reset_n                 clock, asynchronous active-low reset
//  io_req, mode, address,
//  write_data                   request from the I/O controller (sampled at accept)
//  mem_done                     one-cycle completion pulse (success, abort, invalid)
//  read_data                    last successfully read word
//  mem_err                      error flag, valid with mem_done, cleared at next accept
//  busy                         accept through the mem_done cycle
//  avm_*                        Avalon-MM master interface (single word, full byteenable)
module mem_request_bridge
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_req,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  output logic                  mem_done,
  output logic [DATA_W-1:0]     read_data,
  output logic                  mem_err,
  output logic                  busy,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid
);

  bridge_state_t state;
  logic          accept;
  logic          in_flight;
  logic          tmo_expired;

  assign accept    = (state == ST_IDLE) && io_req;
  assign in_flight = (state == ST_RD_CMD) || (state == ST_RD_WAIT) || (state == ST_WR_CMD);

  assign avm_byteenable = '1;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (in_flight),
    .expired (tmo_expired)
  );

  // In every in-flight state the completion condition is tested before the
  // timeout, so a completion in the expiry cycle is reported as success.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mem_done      <= 1'b0;
      read_data     <= '0;
      mem_err       <= 1'b0;
      busy          <= 1'b0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      mem_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (io_req) begin
            busy        <= 1'b1;
            mem_err     <= 1'b0;
            avm_address <= address;
            if (!mode_is_valid(mode)) begin
              state    <= ST_DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
            end else if (mode == MODE_READ) begin
              state    <= ST_RD_CMD;
              avm_read <= 1'b1;
            end else begin
              state         <= ST_WR_CMD;
              avm_write     <= 1'b1;
              avm_writedata <= write_data;
            end
          end
        end
        ST_RD_CMD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_RD_WAIT;
          end else if (tmo_expired) begin
            avm_read <= 1'b0;
            state    <= ST_DONE;
            mem_done <= 1'b1;
            mem_err  <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (avm_readdatavalid) begin
            read_data <= avm_readdata;
            state     <= ST_DONE;
            mem_done  <= 1'b1;
          end else if (tmo_expired) begin
            state    <= ST_DONE;
            mem_done <= 1'b1;
            mem_err  <= 1'b1;
          end
        end
        ST_WR_CMD: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            state     <= ST_DONE;
            mem_done  <= 1'b1;
          end else if (tmo_expired) begin
            avm_write <= 1'b0;
            state     <= ST_DONE;
            mem_done  <= 1'b1;
            mem_err   <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_REARM;
        end
        ST_REARM: begin
          // A request level still held from the finished transaction must
          // not start another one.
          if (!io_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_bridge.sv
module tb_mem_request_bridge;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int T  = 16;
  localparam logic [1:0] M_RD = 2'b01;
  localparam logic [1:0] M_WR = 2'b10;

  logic          clk;
  logic          reset_n;
  logic          io_req;
  logic [1:0]    mode;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          mem_done;
  logic [DW-1:0] read_data;
  logic          mem_err;
  logic          busy;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] model_rd = '0;

  mem_request_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .io_req(io_req), .mode(mode), .address(address),
    .write_data(write_data), .mem_done(mem_done), .read_data(read_data), .mem_err(mem_err),
    .busy(busy), .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request through a scripted slave. Sample k=0 is taken at the falling
  // edge just after the accept edge. The slave stalls the first w strobe
  // cycles, and returns read data lat cycles after acceptance (lat=0: never).
  task automatic run_txn(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int w, input int lat, input logic [DW-1:0] rd, input int hold,
                         input bit scramble, input bit drop_early, input bit spurious,
                         input bit late, input string name);
    int exp_done, exp_rs, exp_ws, c;
    bit exp_err;
    logic [DW-1:0] exp_rd;
    int obs_done, n_done, n_busy, n_rs, n_ws;
    logic obs_err, err0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wd;

    exp_rd = model_rd; exp_rs = 0; exp_ws = 0;
    if (m == M_RD) begin
      c = (lat == 0) ? 1000 : w + 1 + lat;
      exp_rs = (w + 1 < T) ? w + 1 : T;
      if (c <= T) begin exp_done = c; exp_err = 1'b0; exp_rd = rd; end
      else begin exp_done = T; exp_err = 1'b1; end
    end else if (m == M_WR) begin
      c = w + 1;
      if (c <= T) begin exp_done = c; exp_err = 1'b0; exp_ws = c; end
      else begin exp_done = T; exp_err = 1'b1; exp_ws = T; end
    end else begin
      exp_done = 0; exp_err = 1'b1;
    end

    obs_done = -1; n_done = 0; n_busy = 0; n_rs = 0; n_ws = 0;
    obs_err = 1'b0; err0 = 1'b0; last_addr = '0; last_wd = '0;

    @(negedge clk);
    io_req = 1'b1; mode = m; address = a; write_data = wd;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (mem_done) begin
        n_done++;
        if (obs_done < 0) begin obs_done = k; obs_err = mem_err; end
      end
      if (busy) n_busy++;
      if (avm_read) begin n_rs++; last_addr = avm_address; end
      if (avm_write) begin n_ws++; last_addr = avm_address; last_wd = avm_writedata; end
      if (k == 0) err0 = mem_err;
      if (scramble && io_req) begin
        mode = 2'($urandom); address = AW'($urandom); write_data = DW'($urandom);
      end
      if (drop_early && k == 0) io_req = 1'b0;
      if (obs_done >= 0 && k >= obs_done + hold) io_req = 1'b0;
      avm_waitrequest = (k < w);
      avm_readdatavalid = (m == M_RD) && (lat > 0) && (k == w + lat);
      avm_readdata = avm_readdatavalid ? rd : DW'($urandom);
      if (spurious && k == 0) begin avm_readdatavalid = 1'b1; avm_readdata = ~rd; end
      if (late && obs_done >= 0 && (k == obs_done || k == obs_done + 2)) begin
        avm_readdatavalid = 1'b1; avm_readdata = 16'h1234;
      end
    end
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0; io_req = 1'b0;

    n_checks++;
    if (obs_done !== exp_done) $display("FAIL %s done_cycle: got %0d expected %0d", name, obs_done, exp_done);
    else n_pass++;
    n_checks++;
    if (obs_err !== exp_err) $display("FAIL %s mem_err_at_done: got %0b expected %0b", name, obs_err, exp_err);
    else n_pass++;
    n_checks++;
    if (n_done !== 1) $display("FAIL %s done_pulses: got %0d expected 1", name, n_done);
    else n_pass++;
    n_checks++;
    if (n_busy !== exp_done + 1) $display("FAIL %s busy_cycles: got %0d expected %0d", name, n_busy, exp_done + 1);
    else n_pass++;
    n_checks++;
    if (n_rs !== exp_rs) $display("FAIL %s read_strobe_cycles: got %0d expected %0d", name, n_rs, exp_rs);
    else n_pass++;
    n_checks++;
    if (n_ws !== exp_ws) $display("FAIL %s write_strobe_cycles: got %0d expected %0d", name, n_ws, exp_ws);
    else n_pass++;
    n_checks++;
    if (err0 !== !(m == M_RD || m == M_WR)) $display("FAIL %s mem_err_after_accept: got %0b", name, err0);
    else n_pass++;
    n_checks++;
    if (read_data !== exp_rd) $display("FAIL %s read_data: got %h expected %h", name, read_data, exp_rd);
    else n_pass++;
    if (n_rs + n_ws > 0) begin
      n_checks++;
      if (last_addr !== a) $display("FAIL %s avm_address: got %h expected %h", name, last_addr, a);
      else n_pass++;
    end
    if (n_ws > 0) begin
      n_checks++;
      if (last_wd !== wd) $display("FAIL %s avm_writedata: got %h expected %h", name, last_wd, wd);
      else n_pass++;
    end
    model_rd = exp_rd;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; io_req = 1'b0; mode = 2'b00; address = '0; write_data = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_done, mem_err, busy, avm_read, avm_write, read_data, avm_address, avm_writedata} !== '0)
      $display("FAIL reset outputs: got done=%b err=%b busy=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h expected all 0",
               mem_done, mem_err, busy, avm_read, avm_write, read_data, avm_address, avm_writedata);
    else n_pass++;
    n_checks++;
    if (avm_byteenable !== 2'b11) $display("FAIL reset byteenable: got %b expected 11", avm_byteenable);
    else n_pass++;
    reset_n = 1'b1;
    model_rd = '0;
  endtask

  task automatic test_read();
    run_txn(M_RD, 25'h0_01_23, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 0, 0, 0, "read_zero_wait");
  endtask

  task automatic test_write_wait();
    run_txn(M_WR, 25'h1_FF_00, 16'hA55A, 3, 1, 16'h0000, 0, 0, 0, 0, 0, "write_wait3");
  endtask

  task automatic test_hold_high();
    run_txn(M_WR, 25'h0_0A_BC, 16'h1357, 0, 1, 16'h0000, 20, 0, 0, 0, 0, "hold_high_20");
  endtask

  task automatic test_timeout();
    run_txn(M_RD, 25'h0_44_44, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 1, "read_timeout");
  endtask

  task automatic test_invalid();
    run_txn(2'b11, 25'h0_00_10, 16'hFFFF, 0, 1, 16'h0000, 0, 0, 0, 0, 0, "invalid_mode11");
  endtask

  task automatic test_boundaries();
    run_txn(M_WR, 25'h0_12_34, 16'h5A5A, T - 1, 1, 16'h0000, 0, 0, 0, 0, 0, "write_complete_at_expiry");
    run_txn(M_WR, 25'h0_12_35, 16'h6B6B, T, 1, 16'h0000, 0, 0, 0, 0, 0, "write_timeout");
    run_txn(M_RD, 25'h0_22_22, 16'h0000, 2, 2, 16'hC0DE, 0, 0, 0, 1, 0, "read_spurious_rdv_in_cmd");
    run_txn(M_RD, 25'h0_33_33, 16'h0000, 1, 3, 16'h7788, 0, 1, 1, 0, 0, "read_scramble_drop_early");
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    io_req = 1'b1; mode = M_WR; address = 25'h0_0F_0F; write_data = 16'h9999; avm_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (avm_write !== 1'b1) $display("FAIL midreset write_active: got %b expected 1", avm_write);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (avm_write !== 1'b0) $display("FAIL midreset write_drop: got %b expected 0", avm_write);
    else n_pass++;
    n_checks++;
    if ({mem_done, mem_err, busy, avm_read, read_data, avm_address, avm_writedata} !== '0)
      $display("FAIL midreset outputs: got done=%b err=%b busy=%b rdata=%h addr=%h expected all 0",
               mem_done, mem_err, busy, read_data, avm_address);
    else n_pass++;
    io_req = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_rd = '0;
    run_txn(M_RD, 25'h0_05_05, 16'h0000, 0, 1, 16'h4321, 0, 0, 0, 0, 0, "read_after_reset");
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int i = 0; i < 8; i++) begin
      m = 2'($urandom_range(0, 3));
      run_txn(m, AW'($urandom), DW'($urandom), $urandom_range(0, 3), $urandom_range(1, 3),
              DW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_hold_high();
    test_timeout();
    test_invalid();
    test_boundaries();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
